// File: rtl/ps2_key_pkg.sv
// Shared constants for the PS/2 key decoder: key indices, protocol bytes
// and the prefix-tracking FSM state type.
package ps2_key_pkg;

   localparam int NUM_KEYS_DEFAULT = 29;

   localparam logic [4:0] KEY_TILDE     = 5'd0,  KEY_1         = 5'd1,  KEY_2         = 5'd2;
   localparam logic [4:0] KEY_3         = 5'd3,  KEY_4         = 5'd4,  KEY_5         = 5'd5;
   localparam logic [4:0] KEY_6         = 5'd6,  KEY_7         = 5'd7,  KEY_8         = 5'd8;
   localparam logic [4:0] KEY_9         = 5'd9,  KEY_0         = 5'd10, KEY_MINUS     = 5'd11;
   localparam logic [4:0] KEY_EQUAL     = 5'd12, KEY_BACKSPACE = 5'd13, KEY_TAB       = 5'd14;
   localparam logic [4:0] KEY_Q         = 5'd15, KEY_W         = 5'd16, KEY_E         = 5'd17;
   localparam logic [4:0] KEY_R         = 5'd18, KEY_T         = 5'd19, KEY_Y         = 5'd20;
   localparam logic [4:0] KEY_U         = 5'd21, KEY_I         = 5'd22, KEY_O         = 5'd23;
   localparam logic [4:0] KEY_P         = 5'd24, KEY_LBRACKET  = 5'd25, KEY_RBRACKET  = 5'd26;
   localparam logic [4:0] KEY_BACKSLASH = 5'd27, KEY_SPACEBAR  = 5'd28;

   localparam logic [7:0] CODE_BREAK = 8'hF0;
   localparam logic [7:0] CODE_EXT   = 8'hE0;
   localparam logic [7:0] CODE_ACK   = 8'hFA;
   localparam logic [7:0] CODE_BAT   = 8'hAA;
   localparam logic [7:0] CODE_ECHO  = 8'hEE;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_BREAK     = 2'd1,
      ST_EXT       = 2'd2,
      ST_EXT_BREAK = 2'd3
   } ps2_state_e;

endpackage

// File: rtl/ps2_scancode_lut.sv
// Combinational map from a set-2 scan code to {hit, key index}.
module ps2_scancode_lut
   import ps2_key_pkg::*;
(
   input  logic [7:0] code,
   output logic       hit,
   output logic [4:0] idx
);

   // Scan-code lookup; anything not listed is a miss.
   always_comb begin
      hit = 1'b1;
      idx = 5'd0;
      case (code)
         8'h0E: idx = KEY_TILDE;
         8'h16: idx = KEY_1;
         8'h1E: idx = KEY_2;
         8'h26: idx = KEY_3;
         8'h25: idx = KEY_4;
         8'h2E: idx = KEY_5;
         8'h36: idx = KEY_6;
         8'h3D: idx = KEY_7;
         8'h3E: idx = KEY_8;
         8'h46: idx = KEY_9;
         8'h45: idx = KEY_0;
         8'h4E: idx = KEY_MINUS;
         8'h55: idx = KEY_EQUAL;
         8'h66: idx = KEY_BACKSPACE;
         8'h0D: idx = KEY_TAB;
         8'h15: idx = KEY_Q;
         8'h1D: idx = KEY_W;
         8'h24: idx = KEY_E;
         8'h2D: idx = KEY_R;
         8'h2C: idx = KEY_T;
         8'h35: idx = KEY_Y;
         8'h3C: idx = KEY_U;
         8'h43: idx = KEY_I;
         8'h44: idx = KEY_O;
         8'h4D: idx = KEY_P;
         8'h54: idx = KEY_LBRACKET;
         8'h5B: idx = KEY_RBRACKET;
         8'h5D: idx = KEY_BACKSLASH;
         8'h29: idx = KEY_SPACEBAR;
         default: begin
            hit = 1'b0;
            idx = 5'd0;
         end
      endcase
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 byte stream to held-key bitmap with make/break pulses.
// Build option KEY_TYPEMATIC_FILTER_EN suppresses press pulses for auto-repeat makes.
module ps2_key_decoder
   import ps2_key_pkg::*;
#(
   parameter int NUM_KEYS       = NUM_KEYS_DEFAULT,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                CLOCK_50,
   input  logic                resetn,
   input  logic [7:0]          ps2_data,
   input  logic                ps2_data_valid,
   output logic [NUM_KEYS-1:0] key_state,
   output logic                key_press_pulse,
   output logic                key_release_pulse,
   output logic [4:0]          last_key,
   output logic                prefix_pending
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   ps2_state_e          state_r;
   logic [CNT_W-1:0]    timeout_cnt_r;
   logic                lut_hit_s;
   logic [4:0]          lut_idx_s;
   logic                mapped_s;
   logic [NUM_KEYS-1:0] key_mask_s;
   logic                press_ok_s;

   ps2_scancode_lut u_lut (
      .code (ps2_data),
      .hit  (lut_hit_s),
      .idx  (lut_idx_s)
   );

   assign mapped_s   = lut_hit_s && (int'(lut_idx_s) < NUM_KEYS);
   assign key_mask_s = {{(NUM_KEYS-1){1'b0}}, 1'b1} << lut_idx_s;

`ifdef KEY_TYPEMATIC_FILTER_EN
   assign press_ok_s = ~|(key_state & key_mask_s);
`else
   assign press_ok_s = 1'b1;
`endif

   // Prefix FSM, idle timeout and all registered outputs.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_r           <= ST_IDLE;
         timeout_cnt_r     <= '0;
         key_state         <= '0;
         key_press_pulse   <= 1'b0;
         key_release_pulse <= 1'b0;
         last_key          <= 5'd0;
         prefix_pending    <= 1'b0;
      end else begin
         key_press_pulse   <= 1'b0;
         key_release_pulse <= 1'b0;
         if (ps2_data_valid) begin
            // A strobe always wins over a coincident timeout expiry.
            timeout_cnt_r <= '0;
            case (state_r)
               ST_IDLE: begin
                  if (ps2_data == CODE_BREAK) begin
                     state_r        <= ST_BREAK;
                     prefix_pending <= 1'b1;
                  end else if (ps2_data == CODE_EXT) begin
                     state_r        <= ST_EXT;
                     prefix_pending <= 1'b1;
                  end else if ((ps2_data == CODE_ACK) || (ps2_data == CODE_BAT) ||
                               (ps2_data == CODE_ECHO)) begin
                     state_r <= ST_IDLE;
                  end else if (mapped_s) begin
                     key_state       <= key_state | key_mask_s;
                     last_key        <= lut_idx_s;
                     key_press_pulse <= press_ok_s;
                  end else begin
                     state_r <= ST_IDLE;
                  end
               end
               ST_BREAK: begin
                  state_r        <= ST_IDLE;
                  prefix_pending <= 1'b0;
                  if (mapped_s) begin
                     key_state         <= key_state & ~key_mask_s;
                     last_key          <= lut_idx_s;
                     key_release_pulse <= 1'b1;
                  end
               end
               ST_EXT: begin
                  if (ps2_data == CODE_BREAK) begin
                     state_r        <= ST_EXT_BREAK;
                     prefix_pending <= 1'b1;
                  end else begin
                     state_r        <= ST_IDLE;
                     prefix_pending <= 1'b0;
                  end
               end
               default: begin
                  state_r        <= ST_IDLE;
                  prefix_pending <= 1'b0;
               end
            endcase
         end else if (state_r != ST_IDLE) begin
            if (timeout_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_r        <= ST_IDLE;
               prefix_pending <= 1'b0;
               timeout_cnt_r  <= '0;
            end else begin
               timeout_cnt_r <= timeout_cnt_r + CNT_W'(1);
            end
         end
      end
   end

endmodule
